ssd_mux4: RTL and testbench

//  Downstream display stage for the 4-bit direction counter. Captures each counter

---
 rtl/ssd_mux4_if.sv | 22 ++
 rtl/ssd_mux4.sv | 104 ++++++++++
 tb/tb_ssd_mux4.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ssd_mux4_if.sv
// Purpose: bundles the counter-side load/clear inputs and the display-side outputs of ssd_mux4.
// Latency: n/a (wires only). Backpressure: none; the display stage always accepts ld/clr.
// Clock and reset stay plain ports on the module.
interface ssd_mux4_if;
    logic [3:0]  ssdm_d;
    logic        ssdm_ld;
    logic        ssdm_clr;
    logic [6:0]  ssdm_seg;
    logic        ssdm_dp;
    logic [3:0]  ssdm_an;
    logic [15:0] ssdm_hist;

    modport master (
        output ssdm_d, ssdm_ld, ssdm_clr,
        input  ssdm_seg, ssdm_dp, ssdm_an, ssdm_hist
    );

    modport slave (
        input  ssdm_d, ssdm_ld, ssdm_clr,
        output ssdm_seg, ssdm_dp, ssdm_an, ssdm_hist
    );
endinterface

// File: rtl/ssd_mux4.sv
// Purpose: 4-deep digit history captured on ld, time-multiplexed onto a common-anode 4-digit display.
// Latency: hist visible 1 cycle after the load edge; an/seg/dp registered 1 cycle behind the scan index.
// Backpressure: none; every ld/clr is taken on the edge it is presented.
module ssd_mux4 #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        ssdm_clk,
    input  logic        ssdm_rst,
    ssd_mux4_if.slave   bus
);

    localparam int              CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [15:0]   hist;
    logic [3:0]    valid;
    logic          ovf;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic [3:0]    cur_dig;
    logic [3:0]    lz;
    logic          blank;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // lz[i]: digit i is zero and every valid digit above it is zero too
    always_comb begin
        logic above_zero;
        above_zero = 1'b1;
        lz         = 4'b0000;
        for (int j = 3; j >= 0; j--) begin
            lz[j]      = above_zero && (hist[j*4 +: 4] == 4'h0);
            above_zero = above_zero && (!valid[j] || hist[j*4 +: 4] == 4'h0);
        end
        cur_dig = hist[{idx, 2'b00} +: 4];
        blank   = !valid[idx] || (BLANK_LZ && (idx != 2'd0) && lz[idx]);
    end

    always_ff @(posedge ssdm_clk or negedge ssdm_rst) begin
        if (!ssdm_rst) begin
            hist  <= 16'h0000;
            valid <= 4'b0000;
            ovf   <= 1'b0;
            cnt   <= '0;
            idx   <= 2'd0;
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            if (bus.ssdm_clr) begin
                hist  <= 16'h0000;
                valid <= 4'b0000;
                ovf   <= 1'b0;
            end else if (bus.ssdm_ld) begin
                hist  <= {hist[11:0], bus.ssdm_d};
                valid <= {valid[2:0], 1'b1};
                if (valid[3])
                    ovf <= 1'b1;
            end

            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // dp ignores digit blanking so overflow stays visible on an empty top digit
            an_q  <= blank ? 4'hF  : ~(4'b0001 << idx);
            seg_q <= blank ? 7'h7F : seg7(cur_dig);
            dp_q  <= !((idx == 2'd3) && ovf);
        end
    end

    assign bus.ssdm_an   = an_q;
    assign bus.ssdm_seg  = seg_q;
    assign bus.ssdm_dp   = dp_q;
    assign bus.ssdm_hist = hist;

endmodule

// File: tb/tb_ssd_mux4.sv
// Directed walk-through of the display behaviour followed by random load/clear traffic,
// all compared against a digit-list model of the history and scan position.
module tb_ssd_mux4;

    localparam int DIV = 4;
    localparam bit LZ  = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ssd_mux4_if bus ();

    ssd_mux4 #(.REFRESH_DIV(DIV), .BLANK_LZ(LZ)) dut (
        .ssdm_clk (clk),
        .ssdm_rst (rst),
        .bus      (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // model: history as a value with a count of valid digits, scan from elapsed cycles
    int          m_cyc;
    logic [15:0] m_hist;
    int          m_nvalid;
    bit          m_ovf;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] digit_of(input int i);
        return 4'((m_hist >> (4 * i)) & 16'hF);
    endfunction

    task automatic predict(input int idx, output logic [3:0] an, output logic [6:0] seg,
                           output logic dp);
        bit blank;
        blank = (idx >= m_nvalid);
        if (!blank && LZ && idx != 0) begin
            blank = 1'b1;
            for (int j = idx; j < m_nvalid; j++)
                if (digit_of(j) != 4'h0) blank = 1'b0;
        end
        an  = blank ? 4'hF : ~(4'(1 << idx));
        seg = blank ? 7'h7F : seg_tbl[digit_of(idx)];
        dp  = (idx == 3 && m_ovf) ? 1'b0 : 1'b1;
    endtask

    task automatic model_reset();
        m_cyc = 0; m_hist = 16'h0; m_nvalid = 0; m_ovf = 1'b0;
    endtask

    task automatic tick(input bit ld, input logic [3:0] d, input bit clr);
        logic [3:0] ea;
        logic [6:0] es;
        logic       edp;
        bus.ssdm_ld  = ld;
        bus.ssdm_d   = d;
        bus.ssdm_clr = clr;
        predict((m_cyc / DIV) % 4, ea, es, edp);
        if (clr) begin
            m_hist = 16'h0; m_nvalid = 0; m_ovf = 1'b0;
        end else if (ld) begin
            if (m_nvalid == 4) m_ovf = 1'b1;
            else m_nvalid++;
            m_hist = (m_hist << 4) | 16'(d);
        end
        m_cyc++;
        @(posedge clk);
        #1;
        chk("an",   16'(bus.ssdm_an),  16'(ea));
        chk("seg",  16'(bus.ssdm_seg), 16'(es));
        chk("dp",   16'(bus.ssdm_dp),  16'(edp));
        chk("hist", bus.ssdm_hist,     m_hist);
        bus.ssdm_ld  = 1'b0;
        bus.ssdm_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 4'h0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"},   16'(bus.ssdm_an),  16'hF);
        chk({tag, "_seg"},  16'(bus.ssdm_seg), 16'h7F);
        chk({tag, "_dp"},   16'(bus.ssdm_dp),  16'h1);
        chk({tag, "_hist"}, bus.ssdm_hist,     16'h0);
    endtask

    initial begin
        bus.ssdm_d = 4'h0; bus.ssdm_ld = 1'b0; bus.ssdm_clr = 1'b0;
        model_reset();

        // 1: reset held for 3 clocks, released between edges
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        rst = 1'b1;
        idle(2 * DIV);

        // 2: single digit
        tick(1'b1, 4'h5, 1'b0);
        chk("hist_0005", bus.ssdm_hist, 16'h0005);
        idle(4 * DIV + 2);

        // 3: full history 1234
        tick(1'b0, 4'h0, 1'b1);
        tick(1'b1, 4'h1, 1'b0);
        tick(1'b1, 4'h2, 1'b0);
        tick(1'b1, 4'h3, 1'b0);
        tick(1'b1, 4'h4, 1'b0);
        chk("hist_1234", bus.ssdm_hist, 16'h1234);
        idle(4 * DIV + 1);

        // 4: overflow
        tick(1'b1, 4'hF, 1'b0);
        chk("hist_234F", bus.ssdm_hist, 16'h234F);
        idle(4 * DIV + 1);

        // 5: leading-zero blanking on 0070
        tick(1'b0, 4'h0, 1'b1);
        tick(1'b1, 4'h0, 1'b0);
        tick(1'b1, 4'h0, 1'b0);
        tick(1'b1, 4'h7, 1'b0);
        tick(1'b1, 4'h0, 1'b0);
        chk("hist_0070", bus.ssdm_hist, 16'h0070);
        idle(4 * DIV + 1);

        // 6: ld and clr together, clr wins
        tick(1'b1, 4'h9, 1'b0);
        tick(1'b1, 4'hA, 1'b1);
        chk("hist_clr_wins", bus.ssdm_hist, 16'h0000);
        idle(DIV);

        // random load/clear traffic
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 39) == 0));
        end

        // reset mid-window with a populated history
        tick(1'b1, 4'h8, 1'b0);
        tick(1'b1, 4'hC, 1'b0);
        idle(1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst_mid_hold");
        model_reset();
        rst = 1'b1;
        tick(1'b1, 4'h6, 1'b0);
        idle(4 * DIV + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
